// File: rtl/spi_3wire_regmap_bridge.sv
// spi_3wire_regmap_bridge: oversampled 3-wire SPI slave bridging frames onto the register-map bus.
module spi_3wire_regmap_bridge #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int DUMMY_CYCLES = 0,
  parameter int AUTO_INC     = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  button_0,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  sdata_in,
  output logic                  sdata_out,
  output logic                  sdata_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  frame_err
);
  localparam int CMD_BITS = ((ADDR_WIDTH + 8) / 8) * 8;
  localparam int SW = CMD_BITS > DATA_WIDTH ? CMD_BITS : DATA_WIDTH;
  localparam int MAXC = SW > DUMMY_CYCLES ? SW : DUMMY_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, DUMMY, RDATA} state_t;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, sdi_sync_q, sdi_sync_d, vld_q, vld_d;
  logic sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d, armed_q, armed_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic we_q, we_d, re_q, re_d, ld_q, ld_d, oe_q, oe_d, out_q, out_d, ferr_q, ferr_d, busy_q, busy_d;
  logic sclk_s, ss_s, sdi, ok, rise, fall, ss_rise, ss_fall, last_cmd, last_data, last_dummy;
  logic [CMD_BITS-1:0] cmd_word;
  logic [DATA_WIDTH-1:0] data_word;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s = ss_sync_q[SYNC_STAGES-1];
  assign sdi = sdi_sync_q[SYNC_STAGES-1];
  // edges are trusted only once the synchronisers have refilled after reset
  assign ok = vld_q[SYNC_STAGES-1];
  assign rise = ok & sclk_s & ~sclk_prev_q;
  assign fall = ok & ~sclk_s & sclk_prev_q;
  assign ss_rise = ok & ss_s & ~ss_prev_q;
  assign ss_fall = armed_q & ~ss_s & ss_prev_q;
  assign cmd_word = {sh_q[CMD_BITS-2:0], sdi};
  assign data_word = {sh_q[DATA_WIDTH-2:0], sdi};
  assign last_cmd = cnt_q == CW'(CMD_BITS - 1);
  assign last_data = cnt_q == CW'(DATA_WIDTH - 1);
  assign last_dummy = cnt_q == CW'(DUMMY_CYCLES - 1);
  assign sdata_out = out_q;
  assign sdata_oe = oe_q;
  assign reg_addr = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we = we_q;
  assign reg_re = re_q;
  assign busy = busy_q;
  assign frame_err = ferr_q;
  always_comb begin
    sclk_sync_d = SYNC_STAGES'({sclk_sync_q, sclk});
    ss_sync_d = SYNC_STAGES'({ss_sync_q, ss_n});
    sdi_sync_d = SYNC_STAGES'({sdi_sync_q, sdata_in});
    vld_d = SYNC_STAGES'({vld_q, 1'b1});
    sclk_prev_d = sclk_s;
    ss_prev_d = ss_s;
    armed_d = armed_q | (ok & ss_s);
    busy_d = ok & ~ss_s;
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    addr_d = (we_q && AUTO_INC != 0) ? addr_q + 1'b1 : addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    re_d = 1'b0;
    ld_d = re_q;
    oe_d = oe_q;
    out_d = out_q;
    ferr_d = 1'b0;
    if (ld_q) begin
      sh_d = SW'(reg_rdata);
      out_d = reg_rdata[DATA_WIDTH-1];
    end
    if (ss_rise) begin
      state_d = IDLE;
      oe_d = 1'b0;
      ferr_d = (cnt_q != '0) && (state_q inside {CMD, WDATA, RDATA});
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (ss_fall) begin
          state_d = CMD;
          cnt_d = '0;
        end
        CMD: if (rise) begin
          sh_d = SW'(cmd_word);
          cnt_d = last_cmd ? '0 : cnt_q + 1'b1;
          if (last_cmd) begin
            addr_d = cmd_word[ADDR_WIDTH-1:0];
            re_d = cmd_word[ADDR_WIDTH];
            state_d = !cmd_word[ADDR_WIDTH] ? WDATA : DUMMY_CYCLES > 0 ? DUMMY : RDATA;
          end
        end
        WDATA: if (rise) begin
          sh_d = SW'(data_word);
          cnt_d = last_data ? '0 : cnt_q + 1'b1;
          if (last_data) begin
            wdata_d = data_word;
            we_d = 1'b1;
          end
        end
        DUMMY: if (rise) begin
          cnt_d = last_dummy ? '0 : cnt_q + 1'b1;
          state_d = last_dummy ? RDATA : DUMMY;
        end
        RDATA: begin
          oe_d = oe_q | fall | ~sclk_s;
          // a word boundary (cnt 0) leaves the freshly loaded MSB in place
          if (fall && cnt_q != '0) begin
            sh_d = sh_q << 1;
            out_d = sh_d[DATA_WIDTH-1];
          end
          if (rise) begin
            cnt_d = last_data ? '0 : cnt_q + 1'b1;
            re_d = last_data;
            addr_d = (last_data && AUTO_INC != 0) ? addr_q + 1'b1 : addr_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (button_0) begin
      sclk_sync_q <= '0;
      ss_sync_q <= '1;
      sdi_sync_q <= '0;
      vld_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q <= 1'b1;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      ld_q <= 1'b0;
      oe_q <= 1'b0;
      out_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q <= ss_sync_d;
      sdi_sync_q <= sdi_sync_d;
      vld_q <= vld_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q <= ss_prev_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      re_q <= re_d;
      ld_q <= ld_d;
      oe_q <= oe_d;
      out_q <= out_d;
      ferr_q <= ferr_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_spi_3wire_regmap_bridge.sv
// tb_spi_3wire_regmap_bridge: randomized frames on three bridge configurations against a word-level regmap model.
module tb_spi_3wire_regmap_bridge;
  localparam int H = 6;
  logic clk = 0, rst = 1, sclk = 0, sdi = 0;
  logic [2:0] ss_n = 3'b111;
  logic [2:0] so, oe, we, re, ferr, busy;
  logic [2:0][6:0] addr;
  logic [7:0] wd0, wd1, rd0, rd1;
  logic [15:0] wd2, rd2;
  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];
  logic [15:0] mem2 [128];
  logic [15:0] model [3][128];
  int wlog[$], rlog[$];
  int ferr_cnt [3];
  int oe_cnt [3];
  int clash = 0, errs = 0, checks = 0;

  always #5 clk = ~clk;

  spi_3wire_regmap_bridge dut0 (.clk(clk), .button_0(rst), .sclk(sclk), .ss_n(ss_n[0]), .sdata_in(sdi),
    .sdata_out(so[0]), .sdata_oe(oe[0]), .reg_addr(addr[0]), .reg_wdata(wd0), .reg_we(we[0]),
    .reg_re(re[0]), .reg_rdata(rd0), .busy(busy[0]), .frame_err(ferr[0]));
  spi_3wire_regmap_bridge #(.AUTO_INC(0)) dut1 (.clk(clk), .button_0(rst), .sclk(sclk), .ss_n(ss_n[1]),
    .sdata_in(sdi), .sdata_out(so[1]), .sdata_oe(oe[1]), .reg_addr(addr[1]), .reg_wdata(wd1), .reg_we(we[1]),
    .reg_re(re[1]), .reg_rdata(rd1), .busy(busy[1]), .frame_err(ferr[1]));
  spi_3wire_regmap_bridge #(.DATA_WIDTH(16), .DUMMY_CYCLES(2)) dut2 (.clk(clk), .button_0(rst), .sclk(sclk),
    .ss_n(ss_n[2]), .sdata_in(sdi), .sdata_out(so[2]), .sdata_oe(oe[2]), .reg_addr(addr[2]), .reg_wdata(wd2),
    .reg_we(we[2]), .reg_re(re[2]), .reg_rdata(rd2), .busy(busy[2]), .frame_err(ferr[2]));

  // register map environment plus bus activity logging
  always @(posedge clk) begin
    if (we[0]) mem0[addr[0]] <= wd0;
    if (we[1]) mem1[addr[1]] <= wd1;
    if (we[2]) mem2[addr[2]] <= wd2;
    if (re[0]) rd0 <= mem0[addr[0]];
    if (re[1]) rd1 <= mem1[addr[1]];
    if (re[2]) rd2 <= mem2[addr[2]];
    for (int d = 0; d < 3; d++) begin
      if (we[d]) wlog.push_back((d << 24) | (int'(addr[d]) << 16) | int'(d == 0 ? 16'(wd0) : d == 1 ? 16'(wd1) : wd2));
      if (re[d]) rlog.push_back((d << 24) | (int'(addr[d]) << 16));
      if (ferr[d]) ferr_cnt[d]++;
      if (oe[d]) oe_cnt[d]++;
      if (we[d] && re[d]) clash++;
    end
  end

  task automatic xfer(input int d, input logic b, output logic r, output logic o);
    sdi = b;
    repeat (H) @(negedge clk);
    sclk = 1;
    r = so[d];
    o = oe[d];
    repeat (H) @(negedge clk);
    sclk = 0;
  endtask

  task automatic xword(input int d, input int n, input logic [15:0] v, output logic [15:0] rx, output logic [15:0] ov);
    logic r, o;
    rx = '0;
    ov = '0;
    for (int i = n - 1; i >= 0; i--) begin
      xfer(d, v[i], r, o);
      rx[i] = r;
      ov[i] = o;
    end
  endtask

  task automatic sel(input int d);
    @(negedge clk);
    ss_n[d] = 0;
    repeat (H) @(negedge clk);
  endtask

  task automatic desel(input int d);
    repeat (H) @(negedge clk);
    ss_n[d] = 1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic do_write(input int d, input int a, input int n, input logic [63:0] w);
    int dw, inc, wb, fb, ea, ex;
    logic [15:0] r, o, m, ed;
    dw = d == 2 ? 16 : 8;
    inc = d == 1 ? 0 : 1;
    m = dw == 16 ? 16'hFFFF : 16'h00FF;
    wb = wlog.size();
    fb = ferr_cnt[d];
    sel(d);
    xword(d, 8, 16'(a & 127), r, o);
    for (int i = 0; i < n; i++) xword(d, dw, w[i*16 +: 16], r, o);
    desel(d);
    checks++;
    if (wlog.size() - wb != n) begin
      errs++;
      $display("FAIL write_count d%0d a=%0d: got %0d want %0d", d, a, wlog.size() - wb, n);
    end
    for (int i = 0; i < n; i++) begin
      ea = (a + i * inc) % 128;
      ed = w[i*16 +: 16] & m;
      model[d][ea] = ed;
      ex = (d << 24) | (ea << 16) | int'(ed);
      checks++;
      if (wb + i >= wlog.size() || wlog[wb + i] != ex) begin
        errs++;
        $display("FAIL write_word d%0d #%0d: got %h want %h", d, i, wb + i < wlog.size() ? wlog[wb + i] : -1, ex);
      end
    end
    checks++;
    if (ferr_cnt[d] != fb) begin
      errs++;
      $display("FAIL write_frame_err d%0d: got %0d pulses want 0", d, ferr_cnt[d] - fb);
    end
  endtask

  task automatic do_read(input int d, input int a, input int n);
    int dw, dm, inc, rb, fb, ea, ex;
    logic [15:0] r, o, m;
    dw = d == 2 ? 16 : 8;
    dm = d == 2 ? 2 : 0;
    inc = d == 1 ? 0 : 1;
    m = dw == 16 ? 16'hFFFF : 16'h00FF;
    rb = rlog.size();
    fb = ferr_cnt[d];
    sel(d);
    xword(d, 8, 16'(8'h80 | (a & 127)), r, o);
    checks++;
    if (o !== 16'h0) begin
      errs++;
      $display("FAIL oe_cmd d%0d: got %h want 0", d, o);
    end
    if (dm > 0) begin
      xword(d, dm, 16'h0, r, o);
      checks++;
      if (o !== 16'h0) begin
        errs++;
        $display("FAIL oe_dummy d%0d: got %h want 0", d, o);
      end
    end
    for (int i = 0; i < n; i++) begin
      xword(d, dw, 16'h0, r, o);
      ea = (a + i * inc) % 128;
      checks++;
      if (r !== model[d][ea]) begin
        errs++;
        $display("FAIL rdata d%0d addr %0d: got %h want %h", d, ea, r, model[d][ea]);
      end
      checks++;
      if (o !== m) begin
        errs++;
        $display("FAIL oe_data d%0d word %0d: got %h want %h", d, i, o, m);
      end
    end
    desel(d);
    checks++;
    if (oe[d] !== 1'b0) begin
      errs++;
      $display("FAIL oe_end d%0d: got %b want 0", d, oe[d]);
    end
    checks++;
    if (rlog.size() - rb != n + 1) begin
      errs++;
      $display("FAIL read_count d%0d: got %0d want %0d", d, rlog.size() - rb, n + 1);
    end
    for (int i = 0; i <= n; i++) begin
      ea = (a + i * inc) % 128;
      ex = (d << 24) | (ea << 16);
      checks++;
      if (rb + i >= rlog.size() || rlog[rb + i] != ex) begin
        errs++;
        $display("FAIL read_addr d%0d #%0d: got %h want %h", d, i, rb + i < rlog.size() ? rlog[rb + i] : -1, ex);
      end
    end
    checks++;
    if (ferr_cnt[d] != fb) begin
      errs++;
      $display("FAIL read_frame_err d%0d: got %0d pulses want 0", d, ferr_cnt[d] - fb);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({so[d], oe[d], we[d], re[d], busy[d], ferr[d], addr[d]} !== 13'h0) begin
        errs++;
        $display("FAIL reset_outputs d%0d: got %b want 0", d, {so[d], oe[d], we[d], re[d], busy[d], ferr[d], addr[d]});
      end
    end
    checks++;
    if ({wd0, wd1, wd2} !== 32'h0) begin
      errs++;
      $display("FAIL reset_wdata: got %h want 0", {wd0, wd1, wd2});
    end
    rst = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write;
    do_write(0, 0, 4, {16'h71, 16'h1F, 16'h24, 16'hE5});
    for (int k = 0; k < 3; k++) do_write(0, $urandom_range(0, 127), $urandom_range(1, 4), {$urandom, $urandom});
  endtask

  task automatic test_read;
    int a, n;
    do_read(0, 1, 3);
    for (int k = 0; k < 3; k++) begin
      a = $urandom_range(0, 127);
      n = $urandom_range(1, 4);
      do_write(0, a, n, {$urandom, $urandom});
      do_read(0, a, n);
    end
  endtask

  task automatic test_wrap;
    do_write(0, 127, 2, 64'({16'hBB, 16'hAA}));
    do_write(1, 127, 2, 64'({16'hBB, 16'hAA}));
    do_write(1, $urandom_range(0, 127), 3, {$urandom, $urandom});
  endtask

  task automatic test_wide;
    int a;
    do_write(2, 2, 1, 64'($urandom));
    do_read(2, 2, 1);
    a = $urandom_range(0, 127);
    do_write(2, a, 2, {$urandom, $urandom});
    do_read(2, a, 2);
  endtask

  task automatic test_frame_err;
    int wb, fb;
    logic [15:0] r, o;
    wb = wlog.size();
    fb = ferr_cnt[0];
    sel(0);
    checks++;
    if (busy[0] !== 1'b1) begin
      errs++;
      $display("FAIL busy_in_frame: got %b want 1", busy[0]);
    end
    xword(0, 8, 16'h02, r, o);
    xword(0, 5, 16'h15, r, o);
    desel(0);
    checks++;
    if (wlog.size() != wb) begin
      errs++;
      $display("FAIL partial_no_we: got %0d writes want 0", wlog.size() - wb);
    end
    checks++;
    if (ferr_cnt[0] - fb != 1) begin
      errs++;
      $display("FAIL partial_wdata_err: got %0d pulses want 1", ferr_cnt[0] - fb);
    end
    checks++;
    if ({oe[0], busy[0]} !== 2'b00) begin
      errs++;
      $display("FAIL partial_idle: got oe/busy %b want 00", {oe[0], busy[0]});
    end
    do_write(0, 2, 1, 64'h92);
    fb = ferr_cnt[0];
    sel(0);
    xword(0, 3, 16'h5, r, o);
    desel(0);
    checks++;
    if (ferr_cnt[0] - fb != 1) begin
      errs++;
      $display("FAIL partial_cmd_err: got %0d pulses want 1", ferr_cnt[0] - fb);
    end
    fb = ferr_cnt[0];
    sel(0);
    xword(0, 8, 16'h82, r, o);
    xword(0, 3, 16'h0, r, o);
    desel(0);
    checks++;
    if (ferr_cnt[0] - fb != 1 || oe[0] !== 1'b0) begin
      errs++;
      $display("FAIL partial_read_err: got %0d pulses oe %b want 1 pulse oe 0", ferr_cnt[0] - fb, oe[0]);
    end
    do_read(0, 2, 1);
  endtask

  task automatic test_reset_mid;
    int wb, rb, fb, ob, a;
    logic [15:0] r, o;
    sel(0);
    xword(0, 8, 16'h81, r, o);
    xword(0, 3, 16'h0, r, o);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({so[0], oe[0], we[0], re[0], busy[0], ferr[0], addr[0], wd0} !== 21'h0) begin
      errs++;
      $display("FAIL reset_mid_outputs: got %b want 0", {so[0], oe[0], we[0], re[0], busy[0], ferr[0], addr[0], wd0});
    end
    wb = wlog.size();
    rb = rlog.size();
    fb = ferr_cnt[0];
    ob = oe_cnt[0];
    xword(0, 4, 16'(($urandom)), r, o);
    rst = 0;
    xword(0, 16, 16'($urandom), r, o);
    checks++;
    if (wlog.size() != wb || rlog.size() != rb) begin
      errs++;
      $display("FAIL reset_mid_strobes: got %0d we %0d re want 0 0", wlog.size() - wb, rlog.size() - rb);
    end
    checks++;
    if (ferr_cnt[0] != fb || oe_cnt[0] != ob) begin
      errs++;
      $display("FAIL reset_mid_quiet: got %0d err %0d oe cycles want 0 0", ferr_cnt[0] - fb, oe_cnt[0] - ob);
    end
    desel(0);
    a = $urandom_range(0, 127);
    do_write(0, a, 2, {$urandom, $urandom});
    do_read(0, a, 2);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_wide;
    test_frame_err;
    test_reset_mid;
    checks++;
    if (clash != 0) begin
      errs++;
      $display("FAIL we_re_together: got %0d cycles want 0", clash);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
